ibus_mem_responder: RTL and testbench
=====================================

Name: ibus_mem_responder

Overview:
- Instruction-bus responder: the memory end of the fetch-stage ibus protocol. It accepts `ibus_req_t` requests, reads a 32-bit instruction from a local word-addressed array, and returns `ibus_resp_t` with `addr_ok`/`data_ok` handshakes after a configurable latency.
- Used as the instruction-memory model behind fetch in unit and pipeline benches. It replaces the external memory path in standalone builds.

Parameters:
- LATENCY, 2, number of WAIT cycles between request accept and `data_ok`. 0 is legal.
- DEPTH, 1024, number of 32-bit words in the array.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word index 0.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-high.
- ireq  input  ibus_req_t  request: `valid` (1), `addr` (64).
- iresp  output  ibus_resp_t  response: `addr_ok` (1), `data_ok` (1), `data` (32).
- load_en  input  1  bench preload write strobe.
- load_idx  input  $clog2(DEPTH)  preload word index.
- load_data  input  32  preload word.
- busy  output  1  high in WAIT or RESP.
- fault  output  1  qualifies `data_ok`: address misaligned or out of range.
- resp_cnt  output  32  count of completed responses (`data_ok` pulses), wraps at 2^32.

Behaviour:
- Reset (async, any state): state=IDLE; `addr_ok`, `data_ok`, `fault`, `busy` = 0; `data`=0; `resp_cnt`=0; latency counter=0. The array is not cleared. A transaction in flight when reset asserts is dropped with no `data_ok`.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `addr_ok` = `ireq.valid` (combinational).
  - On `ireq.valid`: latch `addr`, set cnt=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT:
  - `addr_ok`=0.
  - cnt decrements each cycle; move to RESP when cnt reaches 1 and is consumed (exactly LATENCY cycles spent in WAIT).
  - If `ireq.valid` drops (flush): cancel, go to IDLE, no `data_ok`, `resp_cnt` unchanged.
- RESP:
  - `data_ok`=1 for exactly one cycle; `resp_cnt` increments; next state IDLE.
  - A new request is accepted no earlier than the following cycle.
  - If `ireq.valid` drops in RESP, `data_ok` is still issued; the requester ignores it.
- Timing: accept in cycle T gives `data_ok` in cycle T+LATENCY+1.
- Address decode on the latched address:
  - idx = (addr − BASE_ADDR) >> 2.
  - Misaligned if addr[1:0]≠0.
  - Out of range if addr<BASE_ADDR or idx≥DEPTH.
  - Either condition: `data`=0 and `fault`=1 with `data_ok`, otherwise `fault`=0.
- Request stability: changes to `ireq.addr` after accept are ignored; the latched address is used.
- Data: `data` = array[idx] read combinationally in the RESP cycle; 0 outside RESP.
- Preload:
  - `load_en` writes array[load_idx] at the clock edge, in any state.
  - A write committed before the RESP cycle is visible in the response.
  - A write in the RESP cycle itself is not visible (old value returned).
  - `load_idx`≥DEPTH is ignored.

Optional Feature:
- Macro: IBUS_RESP_STALL_EN.
- With it defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle.
  - On each accept, LFSR[1:0] extra stall cycles (0–3) are added to WAIT. WAIT is entered even if LATENCY=0 and the extra is >0.
  - The cancel rule applies throughout the stall.
- Without it: latency is exactly LATENCY, and no LFSR is present.

Test Plan:
- Preload idx 0=32'h0000_0013, idx 1=32'h0010_0093; LATENCY=2; valid with addr=0x8000_0000 accepted in cycle 5 → `addr_ok`=1 in cycle 5, `data_ok`=1 in cycle 8 with `data`=32'h0000_0013, `fault`=0, `resp_cnt`=1.
- LATENCY=0; back-to-back requests 0x8000_0000 then 0x8000_0004 with valid held → `data_ok` on alternating cycles, returning 0x0000_0013 then 0x0010_0093; `resp_cnt`=2.
- addr=0x8000_0002 → `data_ok` after LATENCY+1 with `data`=0, `fault`=1. Also addr=0x7FFF_FFFC and addr=BASE+4·DEPTH → `fault`=1.
- LATENCY=4; accept, deassert valid two cycles later → no `data_ok`, `busy`=0 next cycle, `resp_cnt` unchanged; the next request completes normally.
- LATENCY=3; assert reset one cycle after accept → outputs 0 immediately (async); after release, the same request is re-accepted and returns the preloaded word.
- LATENCY=2; `load_en` to the pending idx in the first WAIT cycle with 32'hDEAD_BEEF → response returns 32'hDEAD_BEEF. With IBUS_RESP_STALL_EN, 100 requests each complete in 3–6 cycles after accept.

Source files
------------

// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder: memory end of the fetch-stage instruction bus.
// Accepts a request, waits LATENCY cycles, then returns one word from a
// locally preloadable array with a one-cycle data_ok pulse.
// Optional feature macro: IBUS_RESP_STALL_EN adds 0-3 pseudo-random stall
// cycles per request, drawn from a 16-bit LFSR.

package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_mem_responder
  import ibus_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  ibus_req_t                ireq,
  output ibus_resp_t               iresp,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data,
  output logic                     busy,
  output logic                     fault,
  output logic [31:0]              resp_cnt
);

  localparam int unsigned IDXW    = $clog2(DEPTH);
  localparam logic [63:0] DEPTH64 = 64'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_cnt;
  logic [31:0]       w_cnt_nxt;
  logic [63:0]       r_addr;
  logic [31:0]       r_resp_cnt;
  logic              w_accept;
  logic [31:0]       w_wait_len;

  logic [31:0]       r_mem [DEPTH];

  logic              w_below;
  logic [63:0]       w_off;
  logic [63:0]       w_word;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_bad;
  logic [IDXW-1:0]   w_idx;

`ifdef IBUS_RESP_STALL_EN
  logic [15:0]       r_lfsr;
  logic              w_lfsr_fb;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, free-running every cycle
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // LFSR state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Wait length sampled at accept: base latency plus 0-3 stall cycles
  assign w_wait_len = 32'(LATENCY) + 32'(r_lfsr[1:0]);
`else
  // Wait length is exactly the configured latency
  assign w_wait_len = 32'(LATENCY);
`endif

  // State, latency counter and latched request address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= ireq.addr;
      end
    end
  end

  // Next-state: accept in IDLE, count down in WAIT (cancel on valid drop), one-cycle RESP
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ireq.valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = w_wait_len;
          w_state_nxt = (w_wait_len == 32'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!ireq.valid) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= 32'd1) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - 32'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Completed-response counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_cnt <= '0;
    end else if (r_state == S_RESP) begin
      r_resp_cnt <= r_resp_cnt + 32'd1;
    end
  end

  // Preload port; not reset so contents survive a responder reset
  always_ff @(posedge clk) begin
    if (load_en && (32'(load_idx) < DEPTH)) begin
      r_mem[load_idx] <= load_data;
    end
  end

  // Decode of the latched address into word index and fault conditions
  always_comb begin
    w_below        = (r_addr < BASE_ADDR);
    w_off          = r_addr - BASE_ADDR;
    w_word         = w_off >> 2;
    w_misaligned   = |r_addr[1:0];
    w_out_of_range = w_below || (w_word >= DEPTH64);
    w_bad          = w_misaligned || w_out_of_range;
    w_idx          = w_word[IDXW-1:0];
  end

  // Response outputs; the array read happens in the RESP cycle so a write
  // landing on that same edge is not seen
  always_comb begin
    iresp.addr_ok = !reset && (r_state == S_IDLE) && ireq.valid;
    iresp.data_ok = (r_state == S_RESP);
    iresp.data    = '0;
    if ((r_state == S_RESP) && !w_bad) begin
      iresp.data = r_mem[w_idx];
    end
    fault    = (r_state == S_RESP) && w_bad;
    busy     = (r_state != S_IDLE);
    resp_cnt = r_resp_cnt;
  end

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Directed bench for ibus_mem_responder: four instances with LATENCY 0/2/3/4
// share the request and preload inputs; each test resets them all and
// observes the instance selected through `sel`.
module tb_ibus_mem_responder;
  import ibus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  logic       load_en;
  logic [9:0] load_idx;
  logic [31:0] load_data;

  ibus_resp_t resp0, resp2, resp3, resp4;
  logic       busy0, busy2, busy3, busy4;
  logic       fault0, fault2, fault3, fault4;
  logic [31:0] cnt0, cnt2, cnt3, cnt4;

  int         sel;
  ibus_resp_t m_resp;
  logic       m_busy, m_fault;
  logic [31:0] m_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ibus_mem_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp0), .load_en(load_en),
    .load_idx(load_idx), .load_data(load_data), .busy(busy0), .fault(fault0), .resp_cnt(cnt0));
  ibus_mem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp2), .load_en(load_en),
    .load_idx(load_idx), .load_data(load_data), .busy(busy2), .fault(fault2), .resp_cnt(cnt2));
  ibus_mem_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp3), .load_en(load_en),
    .load_idx(load_idx), .load_data(load_data), .busy(busy3), .fault(fault3), .resp_cnt(cnt3));
  ibus_mem_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp4), .load_en(load_en),
    .load_idx(load_idx), .load_data(load_data), .busy(busy4), .fault(fault4), .resp_cnt(cnt4));

  always_comb begin
    case (sel)
      0:       begin m_resp = resp0; m_busy = busy0; m_fault = fault0; m_cnt = cnt0; end
      3:       begin m_resp = resp3; m_busy = busy3; m_fault = fault3; m_cnt = cnt3; end
      4:       begin m_resp = resp4; m_busy = busy4; m_fault = fault4; m_cnt = cnt4; end
      default: begin m_resp = resp2; m_busy = busy2; m_fault = fault2; m_cnt = cnt2; end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ireq.valid = 1'b0;
    ireq.addr  = '0;
    load_en    = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset      = 1'b0;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_idx  = idx;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic test_reset();
    sel = 2;
    ireq.valid = 1'b0; ireq.addr = '0; load_en = 1'b0; load_idx = '0; load_data = '0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_total++; if ({m_resp.addr_ok, m_resp.data_ok, m_busy, m_fault} !== 4'b0000) $display("FAIL reset_flags: got %b exp 0000", {m_resp.addr_ok, m_resp.data_ok, m_busy, m_fault}); else n_pass++;
    n_total++; if (m_resp.data !== 32'h0) $display("FAIL reset_data: got %h exp 00000000", m_resp.data); else n_pass++;
    n_total++; if (m_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d exp 0", m_cnt); else n_pass++;
    tick();
    reset = 1'b0;
    preload(10'd0,    32'h0000_0013);
    preload(10'd1,    32'h0010_0093);
    preload(10'd2,    32'h1111_1111);
    preload(10'd3,    32'h2222_2222);
    preload(10'd4,    32'h4444_4444);
    preload(10'd5,    32'h5555_5555);
    preload(10'd1023, 32'hCAFE_F00D);
  endtask

  task automatic test_basic();
    sel = 2;
    do_reset();
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0000;
    @(negedge clk);
    n_total++; if (m_resp.addr_ok !== 1'b1) $display("FAIL basic_aok: got %b exp 1", m_resp.addr_ok); else n_pass++;
    n_total++; if (m_resp.data_ok !== 1'b0) $display("FAIL basic_dok_accept: got %b exp 0", m_resp.data_ok); else n_pass++;
    tick();
    ireq.addr = 64'h8000_0004;
    @(negedge clk);
    n_total++; if ({m_resp.addr_ok, m_resp.data_ok, m_busy} !== 3'b001) $display("FAIL basic_wait1: got %b exp 001", {m_resp.addr_ok, m_resp.data_ok, m_busy}); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b0) $display("FAIL basic_wait2_dok: got %b exp 0", m_resp.data_ok); else n_pass++;
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b1) $display("FAIL basic_dok: got %b exp 1", m_resp.data_ok); else n_pass++;
    n_total++; if (m_resp.data !== 32'h0000_0013) $display("FAIL basic_data: got %h exp 00000013", m_resp.data); else n_pass++;
    n_total++; if (m_fault !== 1'b0) $display("FAIL basic_fault: got %b exp 0", m_fault); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (m_cnt !== 32'd1) $display("FAIL basic_cnt: got %0d exp 1", m_cnt); else n_pass++;
    n_total++; if ({m_resp.data_ok, m_busy} !== 2'b00) $display("FAIL basic_idle: got %b exp 00", {m_resp.data_ok, m_busy}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    sel = 0;
    do_reset();
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0000;
    @(negedge clk);
    n_total++; if ({m_resp.addr_ok, m_resp.data_ok} !== 2'b10) $display("FAIL b2b_acc1: got %b exp 10", {m_resp.addr_ok, m_resp.data_ok}); else n_pass++;
    tick();
    ireq.addr = 64'h8000_0004;
    @(negedge clk);
    n_total++; if ({m_resp.addr_ok, m_resp.data_ok} !== 2'b01) $display("FAIL b2b_resp1: got %b exp 01", {m_resp.addr_ok, m_resp.data_ok}); else n_pass++;
    n_total++; if (m_resp.data !== 32'h0000_0013) $display("FAIL b2b_data1: got %h exp 00000013", m_resp.data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({m_resp.addr_ok, m_resp.data_ok} !== 2'b10) $display("FAIL b2b_acc2: got %b exp 10", {m_resp.addr_ok, m_resp.data_ok}); else n_pass++;
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b1) $display("FAIL b2b_resp2: got %b exp 1", m_resp.data_ok); else n_pass++;
    n_total++; if (m_resp.data !== 32'h0010_0093) $display("FAIL b2b_data2: got %h exp 00100093", m_resp.data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (m_cnt !== 32'd2) $display("FAIL b2b_cnt: got %0d exp 2", m_cnt); else n_pass++;
  endtask

  task automatic test_fault();
    logic [63:0] fa [4];
    logic [31:0] fd [4];
    logic        ff [4];
    fa[0] = 64'h8000_0002; fd[0] = 32'h0;         ff[0] = 1'b1;
    fa[1] = 64'h7FFF_FFFC; fd[1] = 32'h0;         ff[1] = 1'b1;
    fa[2] = 64'h8000_1000; fd[2] = 32'h0;         ff[2] = 1'b1;
    fa[3] = 64'h8000_0FFC; fd[3] = 32'hCAFE_F00D; ff[3] = 1'b0;
    sel = 2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      ireq.valid = 1'b1; ireq.addr = fa[i];
      tick();
      tick();
      tick();
      ireq.valid = 1'b0;
      @(negedge clk);
      n_total++; if (m_resp.data_ok !== 1'b1) $display("FAIL fault_dok[%0d]: got %b exp 1", i, m_resp.data_ok); else n_pass++;
      n_total++; if (m_fault !== ff[i]) $display("FAIL fault_flag[%0d]: got %b exp %b", i, m_fault, ff[i]); else n_pass++;
      n_total++; if (m_resp.data !== fd[i]) $display("FAIL fault_data[%0d]: got %h exp %h", i, m_resp.data, fd[i]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush();
    sel = 4;
    do_reset();
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0008;
    tick();
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    n_total++; if ({m_resp.data_ok, m_busy} !== 2'b01) $display("FAIL flush_wait: got %b exp 01", {m_resp.data_ok, m_busy}); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({m_resp.data_ok, m_busy} !== 2'b00) $display("FAIL flush_idle: got %b exp 00", {m_resp.data_ok, m_busy}); else n_pass++;
    n_total++; if (m_cnt !== 32'd0) $display("FAIL flush_cnt: got %0d exp 0", m_cnt); else n_pass++;
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0008;
    @(negedge clk);
    n_total++; if (m_resp.addr_ok !== 1'b1) $display("FAIL flush_reacc: got %b exp 1", m_resp.addr_ok); else n_pass++;
    repeat (4) tick();
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b0) $display("FAIL flush_early: got %b exp 0", m_resp.data_ok); else n_pass++;
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b1 || m_resp.data !== 32'h1111_1111) $display("FAIL flush_resp: got dok=%b data=%h exp dok=1 data=11111111", m_resp.data_ok, m_resp.data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (m_cnt !== 32'd1) $display("FAIL flush_cnt2: got %0d exp 1", m_cnt); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    sel = 3;
    do_reset();
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_000C;
    @(negedge clk);
    n_total++; if (m_resp.addr_ok !== 1'b1) $display("FAIL rst_acc: got %b exp 1", m_resp.addr_ok); else n_pass++;
    tick();
    reset = 1'b1;
    #1;
    n_total++; if ({m_resp.addr_ok, m_resp.data_ok, m_busy, m_fault} !== 4'b0000) $display("FAIL rst_async: got %b exp 0000", {m_resp.addr_ok, m_resp.data_ok, m_busy, m_fault}); else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_total++; if ({m_resp.addr_ok, m_busy} !== 2'b10) $display("FAIL rst_reacc: got %b exp 10", {m_resp.addr_ok, m_busy}); else n_pass++;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if ({m_resp.data_ok, m_busy} !== 2'b01) $display("FAIL rst_wait: got %b exp 01", {m_resp.data_ok, m_busy}); else n_pass++;
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b1 || m_resp.data !== 32'h2222_2222) $display("FAIL rst_resp: got dok=%b data=%h exp dok=1 data=22222222", m_resp.data_ok, m_resp.data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (m_cnt !== 32'd1) $display("FAIL rst_cnt: got %0d exp 1", m_cnt); else n_pass++;
  endtask

  task automatic test_preload_race();
    sel = 2;
    do_reset();
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0010;
    tick();
    load_en = 1'b1; load_idx = 10'd4; load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b1 || m_resp.data !== 32'hDEAD_BEEF) $display("FAIL load_wait_visible: got dok=%b data=%h exp dok=1 data=deadbeef", m_resp.data_ok, m_resp.data); else n_pass++;
    tick();
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0014;
    tick();
    tick();
    tick();
    ireq.valid = 1'b0;
    load_en = 1'b1; load_idx = 10'd5; load_data = 32'h1234_5678;
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b1 || m_resp.data !== 32'h5555_5555) $display("FAIL load_resp_old: got dok=%b data=%h exp dok=1 data=55555555", m_resp.data_ok, m_resp.data); else n_pass++;
    tick();
    load_en = 1'b0;
    tick();
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0014;
    tick();
    tick();
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    n_total++; if (m_resp.data_ok !== 1'b1 || m_resp.data !== 32'h1234_5678) $display("FAIL load_later: got dok=%b data=%h exp dok=1 data=12345678", m_resp.data_ok, m_resp.data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (m_cnt !== 32'd3) $display("FAIL load_cnt: got %0d exp 3", m_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] exp_w [4];
    int          k;
    logic        done;
    exp_w[0] = 32'h0000_0013; exp_w[1] = 32'h0010_0093;
    exp_w[2] = 32'h1111_1111; exp_w[3] = 32'h2222_2222;
    sel = 2;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      ireq.valid = 1'b1; ireq.addr = 64'h8000_0000 + 64'((i % 4) * 4);
      @(negedge clk);
      n_total++; if (m_resp.addr_ok !== 1'b1) $display("FAIL stall_acc[%0d]: got %b exp 1", i, m_resp.addr_ok); else n_pass++;
      k = 0;
      done = 1'b0;
      while (!done && k < 10) begin
        tick();
        k++;
        @(negedge clk);
        if (m_resp.data_ok === 1'b1) done = 1'b1;
      end
      n_total++; if (!done || k < 3 || k > 6) $display("FAIL stall_lat[%0d]: got %0d cycles (done=%b) exp 3..6", i, k, done); else n_pass++;
      n_total++; if (m_resp.data !== exp_w[i % 4]) $display("FAIL stall_data[%0d]: got %h exp %h", i, m_resp.data, exp_w[i % 4]); else n_pass++;
    end
    tick();
    ireq.valid = 1'b0;
    tick();
    @(negedge clk);
    n_total++; if (m_cnt !== 32'd100) $display("FAIL stall_cnt: got %0d exp 100", m_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
`ifdef IBUS_RESP_STALL_EN
    test_stall();
`else
    test_basic();
    test_back_to_back();
    test_fault();
    test_flush();
    test_reset_inflight();
    test_preload_race();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
